alu_cmd_driver: RTL and testbench

- Initiator-side companion to the team's registered 4-bit ALU core (ops ADD/SUB/MUL/DIV/AND/OR/XOR/NOT/ENC).
- Accepts tagged operation requests from a host over valid/ready, queues them, and drives operands/opcode to the ALU core one at a time.
- Waits the ALU's registered latency, captures result and flags, masks stale flags, and returns a tagged response over valid/ready.
- Sits between host/scan logic and the ALU core.

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_req_fifo.sv | 63 ++++++
 rtl/alu_cmd_driver.sv | 180 ++++++++++++++++++
 tb/tb_alu_cmd_driver.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode constants, request payload and FSM state type for
// the ALU command driver and its request FIFO.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_MUL = 4'h2;
    localparam logic [3:0] OP_DIV = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_NOT = 4'h7;
    localparam logic [3:0] OP_ENC = 4'h8;
    localparam logic [3:0] OP_MAX = 4'h8;

    localparam logic [7:0] ENC_KEY = 8'hAB;

    // Request payload queued in the FIFO (tag is appended by the user,
    // since its width is a module parameter).
    typedef struct packed {
        logic [3:0] opcode;
        logic [3:0] a;
        logic [3:0] b;
    } alu_req_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } drv_state_e;

    // Only ADD/SUB produce meaningful carry/overflow; the core leaves the
    // previous flags in place for every other op.
    function automatic logic op_has_flags(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// alu_req_fifo: synchronous FIFO of DEPTH x WIDTH entries (DEPTH a power of
// two, >= 2). Read data is the head entry, valid whenever empty_o is low.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push_i, wdata_i write request (caller guarantees !full_o)
//   pop_i           remove head entry (caller guarantees !empty_o)
//   rdata_o         head entry
//   full_o, empty_o occupancy status
module alu_req_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;

    // Storage has no reset; only pointers and count define occupancy.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == CNT_W'(0));

endmodule

// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: queues tagged ALU requests from a host, drives them one at
// a time into the registered 4-bit ALU core, waits ALU_LAT cycles, captures
// result/flags and returns a tagged response over valid/ready.
// Optional build macro ALU_CMD_DIVZERO_EN: DIV with b==0 is rejected like an
// illegal opcode and flagged on the extra rsp_divzero output.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   req_valid/req_ready             request handshake
//   req_opcode/req_a/req_b/req_tag  request payload
//   alu_a/alu_b/alu_opcode          operand/opcode drive to the ALU core
//   alu_result/alu_carry/alu_overflow  ALU core outputs
//   rsp_valid/rsp_ready             response handshake
//   rsp_result/rsp_carry/rsp_overflow/rsp_illegal/rsp_tag  response payload
//   rsp_divzero                     (ALU_CMD_DIVZERO_EN only) DIV by zero
//   busy                            work queued or in flight
module alu_cmd_driver
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned TAG_W   = 2,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_opcode,
    input  logic [3:0]       req_a,
    input  logic [3:0]       req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [3:0]       alu_opcode,
    input  logic [7:0]       alu_result,
    input  logic             alu_carry,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_result,
    output logic             rsp_carry,
    output logic             rsp_overflow,
    output logic             rsp_illegal,
    output logic [TAG_W-1:0] rsp_tag,
`ifdef ALU_CMD_DIVZERO_EN
    output logic             rsp_divzero,
`endif
    output logic             busy
);

    localparam int unsigned REQ_W = $bits(alu_req_t) + TAG_W;
    localparam int unsigned CNT_W = $clog2(ALU_LAT + 1);

    drv_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [TAG_W-1:0] tag_q;

    logic [REQ_W-1:0] fifo_wdata;
    logic [REQ_W-1:0] fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;

    alu_req_t         head_req;
    logic [TAG_W-1:0] head_tag;
    logic             head_illegal_c;
    logic             head_divzero_c;
    logic             head_reject_c;

    // Request queue
    assign req_ready  = !fifo_full;
    assign fifo_push  = req_valid && !fifo_full;
    assign fifo_pop   = (state_q == ST_IDLE) && !fifo_empty;
    assign fifo_wdata = {req_opcode, req_a, req_b, req_tag};

    alu_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REQ_W)
    ) u_req_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign {head_req, head_tag} = fifo_rdata;

    // Requests that never reach the ALU
    assign head_illegal_c = (head_req.opcode > OP_MAX);
`ifdef ALU_CMD_DIVZERO_EN
    assign head_divzero_c = (head_req.opcode == OP_DIV) && (head_req.b == 4'h0);
`else
    assign head_divzero_c = 1'b0;
`endif
    assign head_reject_c  = head_illegal_c || head_divzero_c;

    assign busy = !fifo_empty || (state_q != ST_IDLE);

    // Sequencer: pop, issue, wait for ALU latency, hold response until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            tag_q        <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_opcode   <= '0;
            rsp_valid    <= 1'b0;
            rsp_result   <= '0;
            rsp_carry    <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_illegal  <= 1'b0;
            rsp_tag      <= '0;
`ifdef ALU_CMD_DIVZERO_EN
            rsp_divzero  <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        tag_q <= head_tag;
                        if (head_reject_c) begin
                            // Rejected ops answer immediately; ALU drive untouched.
                            rsp_valid    <= 1'b1;
                            rsp_result   <= '0;
                            rsp_carry    <= 1'b0;
                            rsp_overflow <= 1'b0;
                            rsp_illegal  <= 1'b1;
                            rsp_tag      <= head_tag;
`ifdef ALU_CMD_DIVZERO_EN
                            rsp_divzero  <= head_divzero_c;
`endif
                            state_q      <= ST_RESP;
                        end else begin
                            alu_a      <= head_req.a;
                            alu_b      <= head_req.b;
                            alu_opcode <= head_req.opcode;
                            state_q    <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    cnt_q   <= CNT_W'(ALU_LAT);
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt_q == CNT_W'(1)) begin
                        // Stale flags from non-arithmetic ops are masked here.
                        rsp_valid    <= 1'b1;
                        rsp_result   <= alu_result;
                        rsp_carry    <= op_has_flags(alu_opcode) && alu_carry;
                        rsp_overflow <= op_has_flags(alu_opcode) && alu_overflow;
                        rsp_illegal  <= 1'b0;
                        rsp_tag      <= tag_q;
`ifdef ALU_CMD_DIVZERO_EN
                        rsp_divzero  <= 1'b0;
`endif
                        state_q      <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// tb_alu_cmd_driver: scoreboard bench for alu_cmd_driver with a behavioural
// ALU core model, directed cases, backpressure, mid-operation reset and a
// randomized request stream.
module tb_alu_cmd_driver;

    localparam int unsigned DEPTH   = 2;
    localparam int unsigned TAG_W   = 2;
    localparam int unsigned ALU_LAT = 1;

    typedef struct packed {
        logic [7:0]       result;
        logic             carry;
        logic             ovf;
        logic             illegal;
        logic             divzero;
        logic [TAG_W-1:0] tag;
    } rsp_t;

    logic             clk;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_opcode;
    logic [3:0]       req_a;
    logic [3:0]       req_b;
    logic [TAG_W-1:0] req_tag;
    logic [3:0]       alu_a;
    logic [3:0]       alu_b;
    logic [3:0]       alu_opcode;
    logic [7:0]       alu_result;
    logic             alu_carry;
    logic             alu_overflow;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [7:0]       rsp_result;
    logic             rsp_carry;
    logic             rsp_overflow;
    logic             rsp_illegal;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_divzero;
    logic             busy;

    int   checks;
    int   errors;
    rsp_t exp_q[$];
    bit   saw_full;
    bit   hold;
    rsp_t held;
    bit   rand_done;

    alu_cmd_driver #(
        .DEPTH   (DEPTH),
        .TAG_W   (TAG_W),
        .ALU_LAT (ALU_LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_opcode   (req_opcode),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_tag      (req_tag),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_opcode   (alu_opcode),
        .alu_result   (alu_result),
        .alu_carry    (alu_carry),
        .alu_overflow (alu_overflow),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_carry    (rsp_carry),
        .rsp_overflow (rsp_overflow),
        .rsp_illegal  (rsp_illegal),
        .rsp_tag      (rsp_tag),
`ifdef ALU_CMD_DIVZERO_EN
        .rsp_divzero  (rsp_divzero),
`endif
        .busy         (busy)
    );

`ifndef ALU_CMD_DIVZERO_EN
    assign rsp_divzero = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU core arithmetic: returns {overflow, carry, result}
    function automatic logic [9:0] alu_func(input logic [3:0] op, input logic [3:0] a,
                                            input logic [3:0] b);
        int sa, sb, s;
        logic [7:0] r;
        logic c, v;
        sa = (a >= 8) ? int'(a) - 16 : int'(a);
        sb = (b >= 8) ? int'(b) - 16 : int'(b);
        r = 8'h00; c = 1'b0; v = 1'b0;
        case (op)
            4'h0: begin
                r = 8'((int'(a) + int'(b)) % 16);
                c = (int'(a) + int'(b)) > 15;
                s = sa + sb;
                v = (s > 7) || (s < -8);
            end
            4'h1: begin
                r = 8'((int'(a) - int'(b) + 16) % 16);
                c = a >= b;
                s = sa - sb;
                v = (s > 7) || (s < -8);
            end
            4'h2: r = 8'(int'(a) * int'(b));
            4'h3: r = (b == 0) ? 8'h00 : {4'(a % b), 4'(a / b)};
            4'h4: r = {4'h0, a & b};
            4'h5: r = {4'h0, a | b};
            4'h6: r = {4'h0, a ^ b};
            4'h7: r = {4'h0, ~a};
            4'h8: r = {a, b} ^ 8'hAB;
            default: r = 8'h00;
        endcase
        return {v, c, r};
    endfunction

    // Expected response for a request
    function automatic rsp_t exp_of(input logic [3:0] op, input logic [3:0] a,
                                    input logic [3:0] b, input logic [TAG_W-1:0] tag);
        rsp_t e;
        logic [9:0] f;
        e = '0;
        e.tag = tag;
        if (op > 4'h8) begin
            e.illegal = 1'b1;
`ifdef ALU_CMD_DIVZERO_EN
        end else if (op == 4'h3 && b == 4'h0) begin
            e.illegal = 1'b1;
            e.divzero = 1'b1;
`endif
        end else begin
            f = alu_func(op, a, b);
            e.result = f[7:0];
            if (op <= 4'h1) begin
                e.carry = f[8];
                e.ovf   = f[9];
            end
        end
        return e;
    endfunction

    // ALU core model: registered, flags are junk for non-ADD/SUB ops
    logic [9:0] alu_pipe [ALU_LAT];
    always @(posedge clk) begin
        logic [9:0] f;
        f = alu_func(alu_opcode, alu_a, alu_b);
        if (alu_opcode > 4'h1) f[9:8] = 2'($urandom);
        alu_pipe[0] <= f;
        for (int i = 1; i < ALU_LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
    end
    assign alu_result   = alu_pipe[ALU_LAT-1][7:0];
    assign alu_carry    = alu_pipe[ALU_LAT-1][8];
    assign alu_overflow = alu_pipe[ALU_LAT-1][9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expected responses on handshake, checks hold stability
    always @(negedge clk) begin
        rsp_t act;
        rsp_t e;
        act = '{rsp_result, rsp_carry, rsp_overflow, rsp_illegal, rsp_divzero, rsp_tag};
        if (rst) begin
            hold = 1'b0;
        end else begin
            if (req_valid && !req_ready) saw_full = 1'b1;
            if (hold) begin
                checks++;
                if (!rsp_valid || act !== held) begin
                    errors++;
                    $display("FAIL rsp_stable: got v=%0b %0h expected v=1 %0h", rsp_valid, act, held);
                end
            end
            if (rsp_valid && rsp_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected: got %0h expected none", act);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        errors++;
                        $display("FAIL rsp_data: got res=%0h c=%0b v=%0b ill=%0b dz=%0b tag=%0d expected res=%0h c=%0b v=%0b ill=%0b dz=%0b tag=%0d",
                                 act.result, act.carry, act.ovf, act.illegal, act.divzero, act.tag,
                                 e.result, e.carry, e.ovf, e.illegal, e.divzero, e.tag);
                    end
                end
                hold = 1'b0;
            end else if (rsp_valid) begin
                hold = 1'b1;
                held = act;
            end else begin
                hold = 1'b0;
            end
        end
    end

    // Issue one request; caller is aligned just after a rising edge
    task automatic send(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [TAG_W-1:0] tag, input rsp_t e);
        bit done;
        done = 1'b0;
        req_valid = 1'b1; req_opcode = op; req_a = a; req_b = b; req_tag = tag;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL req_timeout: got req_ready=0 expected 1 within 200 cycles");
        end
        @(posedge clk);
        if (done) exp_q.push_back(e);
        #1 req_valid = 1'b0;
    endtask

    task automatic send_m(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                          input logic [TAG_W-1:0] tag);
        send(op, a, b, tag, exp_of(op, a, b, tag));
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        for (int i = 0; i < 500; i++) begin
            if (exp_q.size() == 0 && !busy) break;
            @(negedge clk);
        end
        chk("drain_queue", 32'(exp_q.size()), 32'd0);
        chk("drain_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        rsp_t e;
        int lat;
        checks = 0; errors = 0; saw_full = 1'b0; hold = 1'b0; rand_done = 1'b0;
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_opcode = '0; req_a = '0; req_b = '0; req_tag = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("reset_alu_a", 32'(alu_a), 32'd0);
        chk("reset_alu_b", 32'(alu_b), 32'd0);
        chk("reset_alu_opcode", 32'(alu_opcode), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_fields", 32'({rsp_result, rsp_carry, rsp_overflow, rsp_illegal, rsp_tag}), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd1);

        // Directed cases with explicit expected values
        rsp_ready = 1'b1;
        e = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1};
        send(4'h0, 4'd9, 4'd8, 2'd1, e);
        chk("busy_after_push", 32'(busy), 32'd1);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("add_latency_cycles", 32'(lat - 1), 32'(2 + ALU_LAT));
        @(posedge clk); #1;

        send(4'h1, 4'd3, 4'd5, 2'd2, '{8'h0E, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2});
        send(4'h2, 4'd15, 4'd15, 2'd3, '{8'hE1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3});
        send(4'h3, 4'd13, 4'd4, 2'd0, '{8'h13, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0});
        send(4'h8, 4'd5, 4'd10, 2'd1, '{8'hF1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1});
        send(4'hC, 4'd7, 4'd2, 2'd2, '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2});
        drain();
        chk("illegal_alu_opcode_held", 32'(alu_opcode), 32'h8);
        chk("illegal_alu_a_held", 32'(alu_a), 32'd5);
`ifdef ALU_CMD_DIVZERO_EN
        send(4'h3, 4'd7, 4'd0, 2'd3, '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3});
`else
        send(4'h3, 4'd7, 4'd0, 2'd3, '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3});
`endif
        drain();

        // Backpressure: host stalls responses while four requests queue up
        rsp_ready = 1'b0;
        saw_full = 1'b0;
        fork
            begin
                for (int t = 0; t < 4; t++)
                    send_m(4'($urandom_range(0, 8)), 4'($urandom), 4'($urandom), TAG_W'(t));
            end
            begin
                repeat (10) @(posedge clk);
                #1 rsp_ready = 1'b1;
            end
        join
        chk("backpressure_req_ready_dropped", 32'(saw_full), 32'd1);
        drain();

        // Reset while an op waits on the ALU with two requests queued
        rsp_ready = 1'b0;
        send_m(4'h0, 4'd1, 4'd2, 2'd0);
        send_m(4'h2, 4'd3, 4'd4, 2'd1);
        send_m(4'h4, 4'd5, 4'd6, 2'd2);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_req_ready", 32'(req_ready), 32'd1);
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("midreset_no_rsp", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk); #1;

        // Randomized stream with random response backpressure
        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    logic [3:0] op, a, b;
                    op = 4'($urandom_range(0, 15));
                    a  = 4'($urandom);
                    b  = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom);
                    send_m(op, a, b, TAG_W'(n));
                    if ($urandom_range(0, 2) == 0) begin
                        repeat ($urandom_range(1, 4)) @(posedge clk);
                        #1;
                    end
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 rsp_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
